// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg : shared FSM state encodings and owner constants for the arbiter
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package arb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    I_REQ  = 3'd1,
    I_RESP = 3'd2,
    D_REQ  = 3'd3,
    D_RESP = 3'd4
  } arb_state_t;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_t;

  // Width of a counter able to hold 0..max inclusive.
  function automatic int cnt_width(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/arb_prio_sel.sv
// ---------------------------------------------------------------------------
// arb_prio_sel : next-owner selection from pending requests, starvation count
//                and last owner. Optional macro: MEM_ARB_ROUND_ROBIN_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module arb_prio_sel
  import arb_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 3
) (
  input  logic             i_pend,
  input  logic             d_pend,
  input  logic [CNT_W-1:0] starve_cnt,
  input  owner_t           last_owner,
  output owner_t           next_owner
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic unused_cnt;
  assign unused_cnt = ^starve_cnt;

  always_comb begin
    next_owner = OWNER_I;
    if (i_pend && d_pend) begin
      next_owner = (last_owner == OWNER_D) ? OWNER_I : OWNER_D;
    end else if (d_pend) begin
      next_owner = OWNER_D;
    end
  end
`else
  logic unused_last;
  logic w_starved;

  assign unused_last = (last_owner == OWNER_D);
  // Instruction side wins only once data has hogged the port STARVE_MAX times.
  assign w_starved   = i_pend && (starve_cnt == CNT_W'(STARVE_MAX));

  always_comb begin
    next_owner = OWNER_I;
    if (d_pend && !w_starved) begin
      next_owner = OWNER_D;
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter : shares one memory request/response port between fetch
//                    and data sides. Optional macro: MEM_ARB_ROUND_ROBIN_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] I_PC,
  input  logic        I_Req_Valid,
  output logic        I_Req_Ready,
  output logic        I_Valid,
  input  logic        I_Ready,
  input  logic [31:0] D_Address,
  input  logic        D_MemWrite,
  input  logic        D_MemRead,
  output logic        D_Req_Ready,
  output logic        D_Read_data_Valid,
  input  logic        D_Read_data_Ready,
  output logic [31:0] M_Address,
  output logic        M_MemWrite,
  output logic        M_MemRead,
  input  logic        M_Req_Ready,
  input  logic        M_Read_data_Valid,
  output logic        M_Read_data_Ready
);

  localparam int CNT_W = cnt_width(STARVE_MAX);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  owner_t           r_owner;
  owner_t           w_sel_owner;
  logic [CNT_W-1:0] w_starve_cnt;
  logic             w_i_pend;
  logic             w_d_pend;
  logic             w_grant;

  assign w_i_pend = I_Req_Valid;
  assign w_d_pend = D_MemRead | D_MemWrite;
  assign w_grant  = (r_state == IDLE) && (w_i_pend || w_d_pend);

  arb_prio_sel #(
    .STARVE_MAX (STARVE_MAX),
    .CNT_W      (CNT_W)
  ) u_prio_sel (
    .i_pend     (w_i_pend),
    .d_pend     (w_d_pend),
    .starve_cnt (w_starve_cnt),
    .last_owner (r_owner),
    .next_owner (w_sel_owner)
  );

  // r_owner is both the current owner and the last-granted owner.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_owner <= OWNER_D;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_owner <= w_sel_owner;
      end
    end
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  assign w_starve_cnt = '0;
`else
  logic [CNT_W-1:0] r_starve_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (!I_Req_Valid) begin
      r_starve_cnt <= '0;
    end else if (w_grant && (w_sel_owner == OWNER_I)) begin
      r_starve_cnt <= '0;
    end else if (w_grant && (r_starve_cnt != CNT_W'(STARVE_MAX))) begin
      r_starve_cnt <= r_starve_cnt + CNT_W'(1);
    end
  end

  assign w_starve_cnt = r_starve_cnt;
`endif

  always_comb begin
    w_state_nxt       = r_state;
    I_Req_Ready       = 1'b0;
    I_Valid           = 1'b0;
    D_Req_Ready       = 1'b0;
    D_Read_data_Valid = 1'b0;
    M_Address         = '0;
    M_MemWrite        = 1'b0;
    M_MemRead         = 1'b0;
    M_Read_data_Ready = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_grant) begin
          w_state_nxt = (w_sel_owner == OWNER_I) ? I_REQ : D_REQ;
        end
      end

      I_REQ: begin
        M_Address   = I_PC;
        M_MemRead   = I_Req_Valid;
        I_Req_Ready = M_Req_Ready;
        if (!I_Req_Valid) begin
          w_state_nxt = IDLE;
        end else if (M_Req_Ready) begin
          w_state_nxt = I_RESP;
        end
      end

      I_RESP: begin
        I_Valid           = M_Read_data_Valid;
        M_Read_data_Ready = I_Ready;
        if (M_Read_data_Valid && I_Ready) begin
          w_state_nxt = IDLE;
        end
      end

      D_REQ: begin
        M_Address   = D_Address;
        M_MemWrite  = D_MemWrite;
        M_MemRead   = D_MemRead & ~D_MemWrite;
        D_Req_Ready = M_Req_Ready;
        if (!w_d_pend) begin
          w_state_nxt = IDLE;
        end else if (M_Req_Ready) begin
          // Writes carry no response phase.
          w_state_nxt = D_MemWrite ? IDLE : D_RESP;
        end
      end

      D_RESP: begin
        D_Read_data_Valid = M_Read_data_Valid;
        M_Read_data_Ready = D_Read_data_Ready;
        if (M_Read_data_Valid && D_Read_data_Ready) begin
          w_state_nxt = IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter : scoreboard bench for mem_port_arbiter.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_port_arbiter;

  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] I_PC;
  logic        I_Req_Valid;
  logic        I_Req_Ready;
  logic        I_Valid;
  logic        I_Ready;
  logic [31:0] D_Address;
  logic        D_MemWrite;
  logic        D_MemRead;
  logic        D_Req_Ready;
  logic        D_Read_data_Valid;
  logic        D_Read_data_Ready;
  logic [31:0] M_Address;
  logic        M_MemWrite;
  logic        M_MemRead;
  logic        M_Req_Ready;
  logic        M_Read_data_Valid;
  logic        M_Read_data_Ready;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_MAX(STARVE_MAX)) u_dut (
    .clk               (clk),
    .rst               (rst),
    .I_PC              (I_PC),
    .I_Req_Valid       (I_Req_Valid),
    .I_Req_Ready       (I_Req_Ready),
    .I_Valid           (I_Valid),
    .I_Ready           (I_Ready),
    .D_Address         (D_Address),
    .D_MemWrite        (D_MemWrite),
    .D_MemRead         (D_MemRead),
    .D_Req_Ready       (D_Req_Ready),
    .D_Read_data_Valid (D_Read_data_Valid),
    .D_Read_data_Ready (D_Read_data_Ready),
    .M_Address         (M_Address),
    .M_MemWrite        (M_MemWrite),
    .M_MemRead         (M_MemRead),
    .M_Req_Ready       (M_Req_Ready),
    .M_Read_data_Valid (M_Read_data_Valid),
    .M_Read_data_Ready (M_Read_data_Ready)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
  } mreq_t;

  mreq_t exp_q[$];
  mreq_t mon_e;
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] addr, input logic wr);
    mreq_t e;
    e.addr = addr;
    e.wr   = wr;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory-side monitor: every accepted request must match the next expected one.
  always @(negedge clk) begin
    if (!rst && M_Req_Ready && (M_MemRead || M_MemWrite)) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_unexpected_req", 32'(exp_q.size()), 32'd1);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("sb_addr", M_Address, mon_e.addr);
        check_eq("sb_wr", {31'b0, M_MemWrite}, {31'b0, mon_e.wr});
        check_eq("sb_rd", {31'b0, M_MemRead}, {31'b0, !mon_e.wr});
      end
    end
    if (!rst && I_Req_Ready) begin
      check_eq("d_rdy_in_ireq", {31'b0, D_Req_Ready}, 32'd0);
    end
  end

  // Requesters drop valid after their handshake unless keep is set.
  task automatic run_until_empty(input bit keep, input int max_cycles);
    bit hs_i;
    bit hs_d;
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      @(negedge clk);
      hs_i = I_Req_Valid && I_Req_Ready;
      hs_d = (D_MemRead || D_MemWrite) && D_Req_Ready;
      tick();
      if (!keep && hs_i) I_Req_Valid = 1'b0;
      if (!keep && hs_d) begin
        D_MemRead  = 1'b0;
        D_MemWrite = 1'b0;
      end
      n++;
    end
    check_eq("sb_drain", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    I_Req_Valid = 1'b0;
    D_MemRead   = 1'b0;
    D_MemWrite  = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst               = 1'b1;
    I_PC              = '0;
    I_Req_Valid       = 1'b0;
    I_Ready           = 1'b1;
    D_Address         = '0;
    D_MemWrite        = 1'b0;
    D_MemRead         = 1'b0;
    D_Read_data_Ready = 1'b1;
    M_Req_Ready       = 1'b1;
    M_Read_data_Valid = 1'b1;
    repeat (2) tick();
    rst = 1'b0;

    // Reset / idle state with memory side asserting everything
    @(negedge clk);
    check_eq("rst_mread",   {31'b0, M_MemRead},         32'd0);
    check_eq("rst_mwrite",  {31'b0, M_MemWrite},        32'd0);
    check_eq("rst_maddr",   M_Address,                  32'd0);
    check_eq("rst_irdy",    {31'b0, I_Req_Ready},       32'd0);
    check_eq("rst_drdy",    {31'b0, D_Req_Ready},       32'd0);
    check_eq("rst_ivalid",  {31'b0, I_Valid},           32'd0);
    check_eq("rst_dvalid",  {31'b0, D_Read_data_Valid}, 32'd0);
    check_eq("rst_mrready", {31'b0, M_Read_data_Ready}, 32'd0);

    // Fetch only
    tick();
    I_PC              = 32'h1000;
    I_Req_Valid       = 1'b1;
    M_Read_data_Valid = 1'b0;
    push_exp(32'h1000, 1'b0);
    @(negedge clk);
    check_eq("f_latency_mread", {31'b0, M_MemRead}, 32'd0);
    tick();
    @(negedge clk);
    check_eq("f_mread", {31'b0, M_MemRead},   32'd1);
    check_eq("f_maddr", M_Address,            32'h1000);
    check_eq("f_irdy",  {31'b0, I_Req_Ready}, 32'd1);
    tick();
    I_Req_Valid = 1'b0;
    @(negedge clk);
    check_eq("f_resp_wait_ivalid", {31'b0, I_Valid},           32'd0);
    check_eq("f_resp_mrready",     {31'b0, M_Read_data_Ready}, 32'd1);
    M_Read_data_Valid = 1'b1;
    #1;
    check_eq("f_resp_ivalid", {31'b0, I_Valid}, 32'd1);
    tick();
    @(negedge clk);
    check_eq("f_idle_ivalid", {31'b0, I_Valid}, 32'd0);
    check_eq("f_sb_empty", 32'(exp_q.size()), 32'd0);

    // Simultaneous instruction and data reads: data first
    tick();
    I_PC        = 32'h2000;
    I_Req_Valid = 1'b1;
    D_Address   = 32'h8000;
    D_MemRead   = 1'b1;
    push_exp(32'h8000, 1'b0);
    push_exp(32'h2000, 1'b0);
    run_until_empty(1'b0, 20);

    // Data write (read also raised to confirm it is masked)
    D_Address  = 32'h8004;
    D_MemWrite = 1'b1;
    D_MemRead  = 1'b1;
    push_exp(32'h8004, 1'b1);
    @(negedge clk);
    check_eq("w_latency_mwrite", {31'b0, M_MemWrite}, 32'd0);
    tick();
    @(negedge clk);
    check_eq("w_mwrite", {31'b0, M_MemWrite},  32'd1);
    check_eq("w_mread",  {31'b0, M_MemRead},   32'd0);
    check_eq("w_drdy",   {31'b0, D_Req_Ready}, 32'd1);
    tick();
    D_MemWrite = 1'b0;
    D_MemRead  = 1'b0;
    @(negedge clk);
    check_eq("w_no_resp_dvalid", {31'b0, D_Read_data_Valid}, 32'd0);
    check_eq("w_no_resp_mrrdy",  {31'b0, M_Read_data_Ready}, 32'd0);
    check_eq("w_idle_maddr",     M_Address,                  32'd0);
    check_eq("w_idle_mwrite",    {31'b0, M_MemWrite},        32'd0);

    // Continuous requests from both sides
    tick();
    I_PC        = 32'h3000;
    I_Req_Valid = 1'b1;
    D_Address   = 32'h9000;
    D_MemRead   = 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    push_exp(32'h3000, 1'b0);
    push_exp(32'h9000, 1'b0);
    push_exp(32'h3000, 1'b0);
    push_exp(32'h9000, 1'b0);
`else
    for (int i = 0; i < STARVE_MAX; i++) push_exp(32'h9000, 1'b0);
    push_exp(32'h3000, 1'b0);
`endif
    run_until_empty(1'b1, 80);

    // Reset while a data read response is outstanding
    D_Address         = 32'hA000;
    D_MemRead         = 1'b1;
    M_Read_data_Valid = 1'b0;
    push_exp(32'hA000, 1'b0);
    tick();
    @(negedge clk);
    check_eq("r_drdy", {31'b0, D_Req_Ready}, 32'd1);
    tick();
    D_MemRead = 1'b0;
    @(negedge clk);
    check_eq("r_resp_dvalid", {31'b0, D_Read_data_Valid}, 32'd0);
    check_eq("r_resp_mrrdy",  {31'b0, M_Read_data_Ready}, 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst               = 1'b0;
    M_Read_data_Valid = 1'b1;
    @(negedge clk);
    check_eq("r_after_dvalid", {31'b0, D_Read_data_Valid}, 32'd0);
    check_eq("r_after_mrrdy",  {31'b0, M_Read_data_Ready}, 32'd0);
    check_eq("r_after_mread",  {31'b0, M_MemRead},         32'd0);
    check_eq("r_after_maddr",  M_Address,                  32'd0);
    tick();
    @(negedge clk);
    check_eq("r_late_dvalid", {31'b0, D_Read_data_Valid}, 32'd0);

    // Both pending right after reset (last owner is data)
    tick();
    I_PC        = 32'h4000;
    I_Req_Valid = 1'b1;
    D_Address   = 32'hB000;
    D_MemRead   = 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    push_exp(32'h4000, 1'b0);
    push_exp(32'hB000, 1'b0);
`else
    push_exp(32'hB000, 1'b0);
    push_exp(32'h4000, 1'b0);
`endif
    run_until_empty(1'b0, 20);

    // Fetch request withdrawn before memory accepts it
    M_Req_Ready = 1'b0;
    I_PC        = 32'h5000;
    I_Req_Valid = 1'b1;
    tick();
    @(negedge clk);
    check_eq("a_mread", {31'b0, M_MemRead},   32'd1);
    check_eq("a_maddr", M_Address,            32'h5000);
    check_eq("a_irdy",  {31'b0, I_Req_Ready}, 32'd0);
    I_Req_Valid = 1'b0;
    tick();
    @(negedge clk);
    check_eq("a_idle_mread", {31'b0, M_MemRead}, 32'd0);
    check_eq("a_idle_maddr", M_Address,          32'd0);
    tick();
    M_Req_Ready = 1'b1;
    D_Address   = 32'hC000;
    D_MemRead   = 1'b1;
    push_exp(32'hC000, 1'b0);
    run_until_empty(1'b0, 20);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
